ecc_mem_sequencer: RTL and testbench

- Hardware sequencer for the program-2 SECDED decode task: walks NUM_MSG two-byte codewords in data memory, decodes and corrects each, writes the result words back, then raises done.
- Sits beside dm1 in top_level as an alternative memory master to the core; the core hands off with start and waits on done.

---
 rtl/ecc_pkg.sv | 40 ++++
 rtl/ecc_mem_sequencer_if.sv | 10 +
 rtl/secded_decode.sv | 24 ++
 rtl/ecc_mem_sequencer.sv | 119 +++++++++++
 tb/tb_ecc_mem_sequencer.sv | 168 ++++++++++++++++
 5 files changed

// File: rtl/ecc_pkg.sv
// ecc_pkg: shared FSM states, flag codes, codeword bit positions and SECDED helpers
// for the codeword sequencer.
package ecc_pkg;

    typedef enum logic [2:0] {IDLE, RD_HI, RD_LO, WR_HI, WR_LO, DONE} state_t;

    localparam logic [1:0] FLAG_NONE = 2'b00;
    localparam logic [1:0] FLAG_SGL  = 2'b01;
    localparam logic [1:0] FLAG_DBL  = 2'b10;

    localparam int P0 = 0;
    localparam int P1 = 1;
    localparam int P2 = 2;
    localparam int P4 = 4;
    localparam int P8 = 8;

    function automatic logic [3:0] syndrome(input logic [15:0] cw);
        logic [3:0] s;
        s = '0;
        for (int k = 1; k < 16; k++)
            if (cw[k]) s ^= k[3:0];
        return s;
    endfunction

    // Data bits occupy every non-parity position, in ascending order d1..d11.
    function automatic logic [11:1] extract_data(input logic [15:0] cw);
        logic [11:1] d;
        int j;
        d = '0;
        j = 1;
        for (int k = 1; k < 16; k++) begin
            if (!(k == P1 || k == P2 || k == P4 || k == P8)) begin
                d[j] = cw[k];
                j++;
            end
        end
        return d;
    endfunction

endpackage

// File: rtl/ecc_mem_sequencer_if.sv
// ecc_mem_sequencer_if: byte-wide memory port between the sequencer and dm1.
interface ecc_mem_sequencer_if #(parameter int ADDR_W = 8);
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_rd_data;
    logic              mem_wr_en;
    logic [7:0]        mem_wr_data;

    modport master (output mem_addr, mem_wr_en, mem_wr_data, input mem_rd_data);
    modport slave  (input mem_addr, mem_wr_en, mem_wr_data, output mem_rd_data);
endinterface

// File: rtl/secded_decode.sv
// secded_decode: combinational SECDED decode of one 16-bit codeword into 11 data bits
// and an error flag.
module secded_decode
    import ecc_pkg::*;
(
    input  logic [15:0] cw,
    output logic [11:1] d,
    output logic [1:0]  flag
);

    logic [3:0]  w_s;
    logic        w_q;
    logic [15:0] w_cw_fix;

    // A syndrome of 0 with odd parity points at p0, so flipping bit s stays correct.
    always_comb begin
        w_s      = syndrome(cw);
        w_q      = cw[P0] ^ (^cw[15:1]);
        w_cw_fix = w_q ? cw ^ (16'd1 << w_s) : cw;
        flag     = w_q ? FLAG_SGL : (w_s != 4'd0 ? FLAG_DBL : FLAG_NONE);
        d        = extract_data(w_cw_fix);
    end

endmodule

// File: rtl/ecc_mem_sequencer.sv
// ecc_mem_sequencer: walks NUM_MSG codewords in memory, SECDED-decodes each and writes
// the flagged result words back, counting single and double errors.
module ecc_mem_sequencer
    import ecc_pkg::*;
#(
    parameter int NUM_MSG  = 15,
    parameter int SRC_BASE = 30,
    parameter int DST_BASE = 0,
    parameter int ADDR_W   = 8
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        start,
    ecc_mem_sequencer_if.master         mem,
    output logic                        busy,
    output logic                        done,
    output logic [3:0]                  n_single,
    output logic [3:0]                  n_double
);

    state_t            r_state;
    state_t            w_next;
    logic [ADDR_W-1:0] r_i;
    logic [ADDR_W-1:0] r_addr;
    logic [15:0]       r_cw;
    logic              r_done;
    logic [3:0]        r_n_single;
    logic [3:0]        r_n_double;

    logic [ADDR_W-1:0] w_src;
    logic [ADDR_W-1:0] w_dst;
    logic [ADDR_W-1:0] w_addr;
    logic              w_wr_en;
    logic [7:0]        w_wr_data;
    logic              w_go;
    logic              w_last;
    logic [11:1]       w_d;
    logic [1:0]        w_flag;

    secded_decode u_dec (
        .cw   (r_cw),
        .d    (w_d),
        .flag (w_flag)
    );

    // Address is held in IDLE/DONE so dm1 sees a stable bus while the core owns it.
    always_comb begin
        w_go      = start && (r_state == IDLE || r_state == DONE);
        w_last    = r_i == ADDR_W'(NUM_MSG - 1);
        w_src     = ADDR_W'(SRC_BASE) + (r_i << 1);
        w_dst     = ADDR_W'(DST_BASE) + (r_i << 1);
        w_next    = r_state;
        w_addr    = r_addr;
        w_wr_en   = 1'b0;
        w_wr_data = 8'd0;
        case (r_state)
            IDLE, DONE: w_next = start ? RD_HI : r_state;
            RD_HI: begin
                w_addr = w_src + ADDR_W'(1);
                w_next = RD_LO;
            end
            RD_LO: begin
                w_addr = w_src;
                w_next = WR_HI;
            end
            WR_HI: begin
                w_addr    = w_dst + ADDR_W'(1);
                w_wr_en   = 1'b1;
                w_wr_data = {w_flag, 3'b000, w_d[11:9]};
                w_next    = WR_LO;
            end
            WR_LO: begin
                w_addr    = w_dst;
                w_wr_en   = 1'b1;
                w_wr_data = w_d[8:1];
                w_next    = w_last ? DONE : RD_HI;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= IDLE;
            r_i        <= '0;
            r_addr     <= '0;
            r_cw       <= '0;
            r_done     <= 1'b0;
            r_n_single <= '0;
            r_n_double <= '0;
        end else begin
            r_state <= w_next;
            r_addr  <= w_addr;
            r_done  <= w_go ? 1'b0 : (r_state == DONE);
            if (r_state == RD_HI) r_cw[15:8] <= mem.mem_rd_data;
            if (r_state == RD_LO) r_cw[7:0] <= mem.mem_rd_data;
            if (w_go) begin
                r_i        <= '0;
                r_n_single <= '0;
                r_n_double <= '0;
            end else begin
                if (r_state == WR_HI) begin
                    r_n_single <= r_n_single + {3'b000, w_flag == FLAG_SGL};
                    r_n_double <= r_n_double + {3'b000, w_flag == FLAG_DBL};
                end
                if (r_state == WR_LO && !w_last) r_i <= r_i + ADDR_W'(1);
            end
        end
    end

    assign mem.mem_addr    = w_addr;
    assign mem.mem_wr_en   = w_wr_en;
    assign mem.mem_wr_data = w_wr_data;
    assign busy            = r_state != IDLE && r_state != DONE;
    assign done            = r_done;
    assign n_single        = r_n_single;
    assign n_double        = r_n_double;

endmodule

// File: tb/tb_ecc_mem_sequencer.sv
// tb_ecc_mem_sequencer: directed passes over a modelled dm1; expected write-backs are
// queued at start and checked by a separate write monitor.
module tb_ecc_mem_sequencer;

    typedef struct packed {
        logic [7:0] addr;
        logic [7:0] data;
    } wr_t;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic       busy;
    logic       done;
    logic [3:0] n_single;
    logic [3:0] n_double;

    int n_cmp = 0;
    int n_err = 0;

    logic [15:0] src    [15];
    logic [7:0]  wr_mem [256];
    logic [7:0]  exp_hi [15];
    logic [7:0]  exp_lo [15];
    wr_t         exp_q  [$];
    wr_t         mon_e;
    logic [7:0]  rd_off;

    ecc_mem_sequencer_if #(.ADDR_W(8)) mem_if ();

    ecc_mem_sequencer dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .mem      (mem_if),
        .busy     (busy),
        .done     (done),
        .n_single (n_single),
        .n_double (n_double)
    );

    always #5 clk = ~clk;

    // Codewords live at 30..59 (read-only here); results land in wr_mem.
    always_comb begin
        rd_off = mem_if.mem_addr - 8'd30;
        if (mem_if.mem_addr >= 8'd30 && mem_if.mem_addr < 8'd60)
            mem_if.mem_rd_data = rd_off[0] ? src[rd_off[4:1]][15:8] : src[rd_off[4:1]][7:0];
        else
            mem_if.mem_rd_data = wr_mem[mem_if.mem_addr];
    end

    always @(posedge clk)
        if (mem_if.mem_wr_en) wr_mem[mem_if.mem_addr] <= mem_if.mem_wr_data;

    task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (mem_if.mem_wr_en) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_write: got addr %h data %h expected none", mem_if.mem_addr, mem_if.mem_wr_data);
            end else begin
                mon_e = exp_q.pop_front();
                check("wr_addr", 16'(mem_if.mem_addr), 16'(mon_e.addr));
                check("wr_data", 16'(mem_if.mem_wr_data), 16'(mon_e.data));
            end
        end
    end

    task automatic push_writes(input int n);
        for (int i = 0; i < n; i++) begin
            exp_q.push_back({8'(2 * i + 1), exp_hi[i]});
            exp_q.push_back({8'(2 * i), exp_lo[i]});
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_addr"}, 16'(mem_if.mem_addr), 16'd0);
        check({tag, "_wr_en"}, 16'(mem_if.mem_wr_en), 16'd0);
        check({tag, "_wr_data"}, 16'(mem_if.mem_wr_data), 16'd0);
        check({tag, "_busy"}, 16'(busy), 16'd0);
        check({tag, "_done"}, 16'(done), 16'd0);
        check({tag, "_n_single"}, 16'(n_single), 16'd0);
        check({tag, "_n_double"}, 16'(n_double), 16'd0);
    endtask

    task automatic start_edge();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic run_pass(input bit pulse20, input logic [3:0] es, input logic [3:0] ed);
        push_writes(15);
        start_edge();
        check("busy_after_start", 16'(busy), 16'd1);
        check("done_cleared", 16'(done), 16'd0);
        for (int e = 1; e <= 60; e++) begin
            @(posedge clk);
            #1 start = pulse20 && e == 19;
        end
        check("done_edge60", 16'(done), 16'd0);
        check("busy_in_done", 16'(busy), 16'd0);
        @(posedge clk);
        #1;
        check("done_edge61", 16'(done), 16'd1);
        check("n_single", 16'(n_single), 16'(es));
        check("n_double", 16'(n_double), 16'(ed));
        check("writes_drained", 16'(exp_q.size()), 16'd0);
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 15; i++) begin
            src[i]    = 16'hB44B;
            exp_hi[i] = 8'h05;
            exp_lo[i] = 8'hA5;
        end
        repeat (2) @(posedge clk);
        #1 check_idle_outputs("reset");
        @(negedge clk) reset = 1'b1;

        // All clean, with a start pulse while busy that must be ignored.
        run_pass(1'b1, 4'd0, 4'd0);

        // p0 error, double error, data-bit error, all-zero, all-one and p8 error.
        src[0] = 16'hB44A; exp_hi[0] = 8'h45; exp_lo[0] = 8'hA5;
        src[1] = 16'hA443; exp_hi[1] = 8'h85; exp_lo[1] = 8'h24;
        src[3] = 16'hB40B; exp_hi[3] = 8'h45; exp_lo[3] = 8'hA5;
        src[4] = 16'h0000; exp_hi[4] = 8'h00; exp_lo[4] = 8'h00;
        src[5] = 16'hFFFF; exp_hi[5] = 8'h07; exp_lo[5] = 8'hFF;
        src[6] = 16'hFEFF; exp_hi[6] = 8'h47; exp_lo[6] = 8'hFF;
        run_pass(1'b0, 4'd3, 4'd1);

        // Restart from DONE, then abort with reset during WR_HI of message 7.
        push_writes(7);
        start_edge();
        check("restart_done_drop", 16'(done), 16'd0);
        check("restart_n_single", 16'(n_single), 16'd0);
        check("restart_n_double", 16'(n_double), 16'd0);
        repeat (30) @(posedge clk);
        #1 check("msg7_wr_hi_addr", 16'(mem_if.mem_addr), 16'd15);
        reset = 1'b0;
        #1 check_idle_outputs("abort");
        check("abort_writes_drained", 16'(exp_q.size()), 16'd0);
        @(negedge clk) reset = 1'b1;

        run_pass(1'b0, 4'd3, 4'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
